// File: rtl/csa13_acc_pkg.sv
// Shared types and defaults for the csa13 accumulator stage.
package csa13_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 13;
  localparam int DEF_CNT_W = 4;

  function automatic int max_terms(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

endpackage

// File: rtl/csa13_accum_seq.sv
// Frame accumulator driving an external 13-bit carry-select adder.
// Optional saturation of the accumulator is enabled by defining CSA13_ACC_SAT_EN.
module csa13_accum_seq
  import csa13_acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_last,
  output logic [WIDTH-1:0] o_add_term1,
  output logic [WIDTH-1:0] o_add_term2,
  input  logic [WIDTH-1:0] i_sum,
  input  logic             i_cout,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_sum,
  output logic             o_out_ovf,
  output logic             o_out_trunc,
  output logic [CNT_W-1:0] o_out_count
);

`ifdef CSA13_ACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(max_terms(CNT_W));

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             ovf, ovf_nxt;
  logic             trunc, trunc_nxt;
  logic             accept;

  function automatic logic [WIDTH-1:0] next_acc(input logic [WIDTH-1:0] sum,
                                                input logic cout,
                                                input logic ovf_prev);
    if (SAT_EN && (cout || ovf_prev)) return '1;
    return sum;
  endfunction

  assign o_add_term1 = acc;
  assign o_add_term2 = i_in_data;

  assign o_in_ready  = i_rst_n && (state != HOLD);
  assign o_out_valid = i_rst_n && (state == HOLD);
  assign accept      = i_in_valid && o_in_ready;
  assign cnt_inc     = cnt + CNT_W'(1);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    trunc_nxt = trunc;
    case (state)
      // IDLE shares the ACCUM path: acc, cnt and ovf are already zero there
      IDLE, ACCUM: begin
        if (accept) begin
          acc_nxt = next_acc(i_sum, i_cout, ovf);
          cnt_nxt = cnt_inc;
          ovf_nxt = ovf | i_cout;
          if (i_in_last) begin
            state_nxt = HOLD;
          end else if (cnt_inc == MAX_CNT) begin
            state_nxt = HOLD;
            trunc_nxt = 1'b1;
          end else begin
            state_nxt = ACCUM;
          end
        end
      end
      HOLD: begin
        if (i_out_ready) begin
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
          trunc_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      trunc <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
      trunc <= trunc_nxt;
    end
  end

  assign o_out_sum   = acc;
  assign o_out_count = cnt;
  assign o_out_ovf   = ovf;
  assign o_out_trunc = trunc;

endmodule

// File: tb/tb_csa13_accum_seq.sv
// Randomized self-checking bench for csa13_accum_seq with a behavioural adder and frame model.
module tb_csa13_accum_seq;

  localparam int W    = 13;
  localparam int CW   = 4;
  localparam int MAXT = 15;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic [W-1:0]  t1, t2, sum;
  logic          cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_ovf;
  logic          out_trunc;
  logic [CW-1:0] out_count;

  int n_chk = 0;
  int n_bad = 0;
  int terms[$];

  csa13_accum_seq dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .i_in_last   (in_last),
    .o_add_term1 (t1),
    .o_add_term2 (t2),
    .i_sum       (sum),
    .i_cout      (cout),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_sum   (out_sum),
    .o_out_ovf   (out_ovf),
    .o_out_trunc (out_trunc),
    .o_out_count (out_count)
  );

  // The external adder the parent would attach
  always_comb {cout, sum} = {1'b0, t1} + {1'b0, t2};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sends the queued terms as one frame and checks the result against plain arithmetic.
  task automatic run_frame(input bit last_on_end, input int stall);
    int n, total, exp_sum;
    bit exp_ovf, exp_trunc;
    n = terms.size();
    total = 0;
    foreach (terms[i]) total += terms[i];
    exp_ovf   = (total > 8191);
    exp_trunc = (n == MAXT) && !last_on_end;
`ifdef CSA13_ACC_SAT_EN
    exp_sum = exp_ovf ? 8191 : total;
`else
    exp_sum = total % 8192;
`endif
    for (int i = 0; i < n; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        in_valid  = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        cycle();
        out_ready = 1'b0;
        chk("gap_rdy", 32'(in_ready), 32'd1);
        chk("gap_vld", 32'(out_valid), 32'd0);
      end
      in_valid = 1'b1;
      in_data  = W'(terms[i]);
      in_last  = last_on_end && (i == n - 1);
      chk("acc_rdy", 32'(in_ready), 32'd1);
      chk("pre_vld", 32'(out_valid), 32'd0);
      cycle();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("res_vld", 32'(out_valid), 32'd1);
    chk("res_rdy", 32'(in_ready), 32'd0);
    chk("res_sum", 32'(out_sum), 32'(exp_sum));
    chk("res_cnt", 32'(out_count), 32'(n));
    chk("res_ovf", 32'(out_ovf), 32'(exp_ovf));
    chk("res_trunc", 32'(out_trunc), 32'(exp_trunc));
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      in_data  = W'($urandom_range(0, 8191));
      in_last  = 1'($urandom_range(0, 1));
      cycle();
      chk("hold_vld", 32'(out_valid), 32'd1);
      chk("hold_rdy", 32'(in_ready), 32'd0);
      chk("hold_sum", 32'(out_sum), 32'(exp_sum));
      chk("hold_cnt", 32'(out_count), 32'(n));
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("rel_vld", 32'(out_valid), 32'd0);
    chk("rel_rdy", 32'(in_ready), 32'd1);
    chk("rel_cnt", 32'(out_count), 32'd0);
    chk("rel_sum", 32'(out_sum), 32'd0);
  endtask

  initial begin
    int len;
    bit lst;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) cycle();
    chk("rst_rdy", 32'(in_ready), 32'd0);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(out_sum), 32'd0);
    chk("rst_cnt", 32'(out_count), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    chk("rst_trunc", 32'(out_trunc), 32'd0);
    rst_n = 1'b1;
    cycle();
    chk("post_rst_rdy", 32'(in_ready), 32'd1);

    terms = '{100, 200, 300};    run_frame(1'b1, 0);
    terms = '{8000, 500};        run_frame(1'b1, 1);
    terms = '{42};               run_frame(1'b1, 0);
    terms = '{5, 6};             run_frame(1'b1, 5);
    terms.delete();
    for (int i = 0; i < MAXT; i++) terms.push_back(1);
    run_frame(1'b0, 2);
    terms.delete();
    for (int i = 0; i < MAXT; i++) terms.push_back(600);
    run_frame(1'b1, 1);

    // Reset in the middle of a frame discards it
    in_valid = 1'b1; in_data = W'(11); in_last = 1'b0;
    cycle();
    in_data = W'(22);
    cycle();
    in_valid = 1'b0;
    rst_n = 1'b0;
    cycle();
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_rdy", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    cycle();
    chk("mid_rel_vld", 32'(out_valid), 32'd0);
    chk("mid_rel_cnt", 32'(out_count), 32'd0);
    chk("mid_rel_sum", 32'(out_sum), 32'd0);
    terms = '{7, 8};             run_frame(1'b1, 0);

    for (int f = 0; f < 40; f++) begin
      terms.delete();
      len = $urandom_range(1, MAXT);
      for (int i = 0; i < len; i++)
        terms.push_back($urandom_range(0, 1) ? $urandom_range(0, 8191) : $urandom_range(0, 600));
      lst = (len < MAXT) ? 1'b1 : 1'($urandom_range(0, 1));
      run_frame(lst, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/csa13_accum_seq.md
Name: csa13_accum_seq

Overview:
- Sequential accumulator stage wrapped around the team's 13-bit carry-select adder. The adder is instantiated beside this block, not inside it.
- Accepts a stream of 13-bit terms over a valid/ready handshake and drives the adder's operand inputs each cycle.
- Captures the adder's sum and carry-out into an accumulator register.
- Presents one accumulated result per frame to a downstream consumer with backpressure.

Parameters:
- WIDTH, 13, operand, sum and accumulator width. Must match the attached adder.
- CNT_W, 4, width of the term counter. MAX_TERMS = 2^CNT_W - 1.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  synchronous active-low reset
- i_in_valid  input  1  term valid
- o_in_ready  output  1  block can accept a term
- i_in_data  input  WIDTH  term value, unsigned
- i_in_last  input  1  final term of frame
- o_add_term1  output  WIDTH  adder operand A (= accumulator, combinational)
- o_add_term2  output  WIDTH  adder operand B (= i_in_data, combinational)
- i_sum  input  WIDTH  adder sum
- i_cout  input  1  adder carry-out
- o_out_valid  output  1  result valid
- i_out_ready  input  1  consumer accepts result
- o_out_sum  output  WIDTH  accumulated frame result
- o_out_ovf  output  1  sticky: a carry-out occurred during the frame
- o_out_trunc  output  1  frame was force-closed at MAX_TERMS
- o_out_count  output  CNT_W  number of terms in the frame

Behaviour:
- One clock, i_clk. Reset is synchronous and active-low on i_rst_n, sampled at the rising edge.
- Reset values:
  - state = IDLE; accumulator = 0; count = 0; ovf = 0; trunc = 0.
  - o_out_valid = 0, o_in_ready = 0 during reset.
  - All result outputs read 0.
- Accept event: i_in_valid & o_in_ready at a rising edge.
- States:
  - IDLE: o_in_ready = 1; accumulator holds 0, so i_sum = i_in_data.
    - On accept: acc <= i_sum; count <= 1; ovf <= i_cout.
    - Next state is HOLD if i_in_last, otherwise ACCUM.
  - ACCUM: o_in_ready = 1.
    - On accept: acc <= i_sum; count <= count + 1; ovf <= ovf | i_cout.
    - Next state is HOLD if i_in_last, or if count + 1 == MAX_TERMS (then trunc <= ~i_in_last).
    - No accept: hold all state.
  - HOLD: o_in_ready = 0; o_out_valid = 1; outputs stable.
    - On i_out_ready: clear acc, count, ovf and trunc; next state is IDLE.
- Timing:
  - Latency: o_out_valid rises the cycle after the last term is accepted.
  - Throughput: one term per cycle. Minimum frame overhead is one HOLD cycle.
- Arithmetic: modulo 2^WIDTH; the carry is recorded only in ovf.
- Output mapping: o_out_sum = acc, o_out_count = count, o_out_ovf = ovf, o_out_trunc = trunc. These are registered outputs, stable through HOLD.
- Boundary conditions:
  - Term presented during HOLD is not accepted; the upstream source holds it.
  - i_in_last on the MAX_TERMS-th term closes the frame normally with trunc = 0.
  - i_out_ready while not in HOLD is ignored.
  - Reset mid-frame discards the partial frame; no result is emitted.
  - o_out_valid only falls after a handshake. It never drops while i_out_ready = 0.

Optional Feature:
- Macro: CSA13_ACC_SAT_EN.
- Defined: on any accept where i_cout = 1, or with ovf already set, acc <= all-ones (8191 for WIDTH = 13). The accumulator stays saturated for the rest of the frame; ovf is still set.
- Not defined: wrap-around modulo 2^WIDTH as described in Behaviour.

Decomposition:
- Package csa13_acc_pkg holds:
  - state enum: IDLE, ACCUM, HOLD
  - default WIDTH (13) and CNT_W (4)
  - MAX_TERMS constant function
- No sub-module. The FSM, counter and accumulator form a single module, and the adder is attached externally by the parent.

Test Plan:
- Terms 100, 200, 300 (last on 300) -> o_out_sum = 600, count = 3, ovf = 0, trunc = 0; o_out_valid one cycle after the third accept.
- Terms 8000 then 500 (last) -> without SAT: sum = 308, ovf = 1; with CSA13_ACC_SAT_EN: sum = 8191, ovf = 1.
- Single term 42 with i_in_last in IDLE -> sum = 42, count = 1, HOLD the next cycle.
- Result pending with i_out_ready low for 5 cycles -> o_out_valid held, o_in_ready = 0, outputs stable; raise ready -> IDLE next cycle, o_in_ready = 1.
- 15 terms of value 1, no last (CNT_W = 4) -> forced close: sum = 15, count = 15, trunc = 1; the 16th term waits until IDLE.
- i_rst_n low for one cycle after 2 of 4 terms -> no result emitted; the next frame 7, 8 (last) gives sum = 15, count = 2.
